// File: rtl/i2c_sensor_reg16_slave_if.sv
// Register-configuration bus bundle for the sensor-side I2C/SCCB slave.
// Raw pins, open-drain SDA pull, write strobe and register-read port.
`timescale 1ns/1ps
interface i2c_sensor_reg16_slave_if;
    logic        scl_i;
    logic        sda_i;
    logic        sda_oe;
    logic        wr_valid;
    logic [15:0] wr_addr;
    logic [7:0]  wr_data;
    logic [15:0] rd_addr;
    logic [7:0]  rd_data;
    logic        busy;

    modport slave (
        input  scl_i, sda_i, rd_data,
        output sda_oe, wr_valid, wr_addr, wr_data, rd_addr, busy
    );

    modport master (
        output scl_i, sda_i, rd_data,
        input  sda_oe, wr_valid, wr_addr, wr_data, rd_addr, busy
    );
endinterface

// File: rtl/i2c_sensor_reg16_slave.sv
// Oversampled I2C/SCCB slave: 7-bit device address, 16-bit register
// pointer, 8-bit data, auto-incrementing write and read bursts.
`timescale 1ns/1ps
module i2c_sensor_reg16_slave (
    input  logic clk,
    input  logic rst_n,
    i2c_sensor_reg16_slave_if.slave bus
);
    localparam logic [6:0] DEV_ADDR = 7'h30;

    typedef enum logic [3:0] {
        IDLE, DEV, DEV_ACK, RA_HI, ACK_HI, RA_LO,
        ACK_LO, WDATA, WACK, RDATA, MACK, WAIT_STOP
    } state_t;

    logic scl_s1, scl_s2, scl_h;
    logic sda_s1, sda_s2, sda_h;

    // Synchronizers are left unreset so a reset never fabricates a START.
    always_ff @(posedge clk) begin
        scl_s1 <= bus.scl_i;
        scl_s2 <= scl_s1;
        scl_h  <= scl_s2;
        sda_s1 <= bus.sda_i;
        sda_s2 <= sda_s1;
        sda_h  <= sda_s2;
    end

    logic scl_rise, scl_fall, start_c, stop_c;

    assign scl_rise = scl_s2 & ~scl_h;
    assign scl_fall = ~scl_s2 & scl_h;
    assign start_c  = scl_s2 & scl_h & sda_h & ~sda_s2;
    assign stop_c   = scl_s2 & scl_h & ~sda_h & sda_s2;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [6:0]  sh_q, sh_d;
    logic [6:0]  tx_q, tx_d;
    logic [7:0]  hi_q, hi_d;
    logic [15:0] ptr_q, ptr_d;
    logic        rw_q, rw_d;
    logic        ph_q, ph_d;
    logic        oe_q, oe_d;
    logic        wv_q, wv_d;
    logic [15:0] wa_q, wa_d;
    logic [7:0]  wd_q, wd_d;
    logic        busy_q, busy_d;

    logic [7:0] byte_in;
    logic       last;

    assign byte_in = {sh_q, sda_s2};
    assign last    = (cnt_q == 3'd7);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            sh_q    <= 7'd0;
            tx_q    <= 7'd0;
            hi_q    <= 8'd0;
            ptr_q   <= 16'd0;
            rw_q    <= 1'b0;
            ph_q    <= 1'b0;
            oe_q    <= 1'b0;
            wv_q    <= 1'b0;
            wa_q    <= 16'd0;
            wd_q    <= 8'd0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            tx_q    <= tx_d;
            hi_q    <= hi_d;
            ptr_q   <= ptr_d;
            rw_q    <= rw_d;
            ph_q    <= ph_d;
            oe_q    <= oe_d;
            wv_q    <= wv_d;
            wa_q    <= wa_d;
            wd_q    <= wd_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        tx_d    = tx_q;
        hi_d    = hi_q;
        ptr_d   = ptr_q;
        rw_d    = rw_q;
        ph_d    = ph_q;
        oe_d    = oe_q;
        wv_d    = 1'b0;
        wa_d    = wa_q;
        wd_d    = wd_q;
        busy_d  = busy_q;

        if (start_c) begin
            state_d = DEV;
            cnt_d   = 3'd0;
            ph_d    = 1'b0;
            oe_d    = 1'b0;
        end else if (stop_c) begin
            state_d = IDLE;
            cnt_d   = 3'd0;
            ph_d    = 1'b0;
            oe_d    = 1'b0;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE, WAIT_STOP: oe_d = 1'b0;
                DEV: if (scl_rise) begin
                    sh_d  = byte_in[6:0];
                    cnt_d = cnt_q + 3'd1;
                    if (last) begin
                        ph_d = 1'b0;
                        if (byte_in[7:1] == DEV_ADDR) begin
                            state_d = DEV_ACK;
                            busy_d  = 1'b1;
                            rw_d    = byte_in[0];
                        end else begin
                            state_d = WAIT_STOP;
                            busy_d  = 1'b0;
                        end
                    end
                end
                RA_HI: if (scl_rise) begin
                    sh_d  = byte_in[6:0];
                    cnt_d = cnt_q + 3'd1;
                    if (last) begin
                        hi_d    = byte_in;
                        ph_d    = 1'b0;
                        state_d = ACK_HI;
                    end
                end
                RA_LO: if (scl_rise) begin
                    sh_d  = byte_in[6:0];
                    cnt_d = cnt_q + 3'd1;
                    if (last) begin
                        ptr_d   = {hi_q, byte_in};
                        ph_d    = 1'b0;
                        state_d = ACK_LO;
                    end
                end
                WDATA: if (scl_rise) begin
                    sh_d  = byte_in[6:0];
                    cnt_d = cnt_q + 3'd1;
                    if (last) begin
                        wv_d    = 1'b1;
                        wa_d    = ptr_q;
                        wd_d    = byte_in;
                        ptr_d   = ptr_q + 16'd1;
                        ph_d    = 1'b0;
                        state_d = WACK;
                    end
                end
                // First fall pulls SDA for the ACK slot, second fall ends it.
                DEV_ACK, ACK_HI, ACK_LO, WACK: if (scl_fall) begin
                    if (!ph_q) begin
                        oe_d = 1'b1;
                        ph_d = 1'b1;
                    end else begin
                        ph_d  = 1'b0;
                        oe_d  = 1'b0;
                        cnt_d = 3'd0;
                        if (state_q == DEV_ACK && rw_q) begin
                            tx_d    = bus.rd_data[6:0];
                            oe_d    = ~bus.rd_data[7];
                            state_d = RDATA;
                        end else if (state_q == DEV_ACK) begin
                            state_d = RA_HI;
                        end else if (state_q == ACK_HI) begin
                            state_d = RA_LO;
                        end else begin
                            state_d = WDATA;
                        end
                    end
                end
                RDATA: if (scl_fall) begin
                    tx_d  = {tx_q[5:0], 1'b0};
                    cnt_d = cnt_q + 3'd1;
                    if (last) begin
                        oe_d    = 1'b0;
                        ph_d    = 1'b0;
                        state_d = MACK;
                    end else begin
                        oe_d = ~tx_q[6];
                    end
                end
                MACK: if (scl_rise) begin
                    if (sda_s2) begin
                        state_d = WAIT_STOP;
                    end else begin
                        ptr_d = ptr_q + 16'd1;
                        ph_d  = 1'b1;
                    end
                end else if (scl_fall && ph_q) begin
                    ph_d    = 1'b0;
                    cnt_d   = 3'd0;
                    tx_d    = bus.rd_data[6:0];
                    oe_d    = ~bus.rd_data[7];
                    state_d = RDATA;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign bus.sda_oe   = oe_q;
    assign bus.wr_valid = wv_q;
    assign bus.wr_addr  = wa_q;
    assign bus.wr_data  = wd_q;
    assign bus.rd_addr  = ptr_q;
    assign bus.busy     = busy_q;
endmodule
